// File: rtl/cic_decimator_mc_pkg.sv
// Shared widths, defaults and helper functions for the multi-channel CIC decimator.
package cic_decimator_mc_pkg;

  localparam int unsigned CIC_IW_DEF    = 19;
  localparam int unsigned CIC_OW_DEF    = 19;
  localparam int unsigned CIC_N_DEF     = 3;
  localparam int unsigned CIC_R_DEF     = 16;
  localparam int unsigned CIC_M_DEF     = 1;
  localparam int unsigned CIC_CH_DEF    = 4;
  localparam int unsigned CIC_SHIFT_DEF = 0;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator width: enough headroom for the R^N * M^N gain.
  function automatic int unsigned cic_aw(input int unsigned iw, input int unsigned n,
                                         input int unsigned r, input int unsigned m);
    return iw + n * clog2(r * m);
  endfunction

  // Channel tag width, never zero.
  function automatic int unsigned cic_cw(input int unsigned ch);
    return (ch > 1) ? clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/cic_decimator_mc_if.sv
// Sample-stream bundle between the front-end and the decimator.
interface cic_decimator_mc_if #(
  parameter int unsigned IW = 19,
  parameter int unsigned OW = 19,
  parameter int unsigned CW = 2
);
  logic signed [IW-1:0] i_data;
  logic                 i_ready;
  logic                 i_first;
  logic signed [OW-1:0] o_data;
  logic                 o_ready;
  logic [CW-1:0]        o_chan;
  logic                 o_sync_err;

  modport master (
    output i_data, i_ready, i_first,
    input  o_data, o_ready, o_chan, o_sync_err
  );

  modport slave (
    input  i_data, i_ready, i_first,
    output o_data, o_ready, o_chan, o_sync_err
  );
endinterface

// File: rtl/cic_decimator_mc_comb_bank.sv
// One CIC comb stage with per-channel differential-delay storage.
module cic_comb_bank
  import cic_decimator_mc_pkg::*;
#(
  parameter int unsigned AW = cic_aw(CIC_IW_DEF, CIC_N_DEF, CIC_R_DEF, CIC_M_DEF),
  parameter int unsigned CW = cic_cw(CIC_CH_DEF),
  parameter int unsigned CH = CIC_CH_DEF,
  parameter int unsigned M  = CIC_M_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [CW-1:0]        chan_i,
  input  logic signed [AW-1:0] data_i,
  output logic                 valid_o,
  output logic [CW-1:0]        chan_o,
  output logic signed [AW-1:0] data_o
);

  logic signed [AW-1:0] dly_q [CH][M];
  logic signed [AW-1:0] data_q;
  logic signed [AW-1:0] data_d;
  logic                 valid_q;
  logic [CW-1:0]        chan_q;

  // Difference against the oldest stored sample of the same channel.
  always_comb begin
    data_d = data_i - dly_q[chan_i][M-1];
  end

  // Register the difference and shift the channel's delay line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
      for (int unsigned c = 0; c < CH; c++) begin
        for (int unsigned m = 0; m < M; m++) begin
          dly_q[c][m] <= '0;
        end
      end
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        chan_q              <= chan_i;
        data_q              <= data_d;
        dly_q[chan_i][0]    <= data_i;
        for (int unsigned m = 1; m < M; m++) begin
          dly_q[chan_i][m] <= dly_q[chan_i][m-1];
        end
      end
    end
  end

  assign valid_o = valid_q;
  assign chan_o  = chan_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cic_decimator_mc.sv
// N-stage multi-channel CIC decimator: integrators -> decimate-by-R -> combs.
module cic_decimator_mc
  import cic_decimator_mc_pkg::*;
#(
  parameter int unsigned IW    = CIC_IW_DEF,
  parameter int unsigned OW    = CIC_OW_DEF,
  parameter int unsigned N     = CIC_N_DEF,
  parameter int unsigned R     = CIC_R_DEF,
  parameter int unsigned M     = CIC_M_DEF,
  parameter int unsigned CH    = CIC_CH_DEF,
  parameter int unsigned SHIFT = CIC_SHIFT_DEF
) (
  input logic              i_clk,
  input logic              i_reset,
  cic_decimator_mc_if.slave io
);

  localparam int unsigned AW = cic_aw(IW, N, R, M);
  localparam int unsigned CW = cic_cw(CH);
  localparam int unsigned FW = clog2(R);

  logic [CW-1:0] ch_q, ch_d, ch_eff;
  logic [FW-1:0] fr_q, fr_d;
  logic          sync_err_q, sync_err_d;
  logic          ch_wrap;
  logic          dec_valid;

  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] integ_q   [N][CH];
  logic signed [AW-1:0] integ_new [N];

  logic                 dec_valid_q;
  logic [CW-1:0]        dec_chan_q;
  logic signed [AW-1:0] dec_data_q;

  logic                 stg_valid [N+1];
  logic [CW-1:0]        stg_chan  [N+1];
  logic signed [AW-1:0] stg_data  [N+1];

  logic signed [AW-1:0] comb_shift;
  logic signed [OW-1:0] o_data_q, o_data_d;
  logic [CW-1:0]        o_chan_q, o_chan_d;
  logic                 o_ready_q, o_ready_d;

  // Channel/frame sequencing; i_first on a nonzero slot forces the sample onto channel 0.
  always_comb begin
    ch_eff     = io.i_first ? '0 : ch_q;
    ch_wrap    = (ch_eff == CW'(CH - 1));
    ch_d       = ch_q;
    fr_d       = fr_q;
    sync_err_d = sync_err_q;
    dec_valid  = 1'b0;
    if (io.i_ready) begin
      ch_d = ch_wrap ? '0 : ch_eff + CW'(1);
      if (ch_wrap) fr_d = (fr_q == FW'(R - 1)) ? '0 : fr_q + FW'(1);
      if (io.i_first && (ch_q != '0)) sync_err_d = 1'b1;
      dec_valid = (fr_q == FW'(R - 1));
    end
  end

  // Counter and sticky sync-error state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ch_q       <= '0;
      fr_q       <= '0;
      sync_err_q <= 1'b0;
    end else begin
      ch_q       <= ch_d;
      fr_q       <= fr_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign x_ext = AW'(io.i_data);

  // Integrator chain for the current channel, all stages updated in one cycle.
  always_comb begin
    integ_new[0] = integ_q[0][ch_eff] + x_ext;
    for (int unsigned k = 1; k < N; k++) begin
      integ_new[k] = integ_q[k][ch_eff] + integ_new[k-1];
    end
  end

  // Integrator state; wrap-around is the intended arithmetic.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned k = 0; k < N; k++) begin
        for (int unsigned c = 0; c < CH; c++) begin
          integ_q[k][c] <= '0;
        end
      end
    end else if (io.i_ready) begin
      for (int unsigned k = 0; k < N; k++) begin
        integ_q[k][ch_eff] <= integ_new[k];
      end
    end
  end

  // Decimated sample register feeding the comb pipeline.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dec_valid_q <= 1'b0;
      dec_chan_q  <= '0;
      dec_data_q  <= '0;
    end else begin
      dec_valid_q <= dec_valid;
      if (dec_valid) begin
        dec_chan_q <= ch_eff;
        dec_data_q <= integ_new[N-1];
      end
    end
  end

  assign stg_valid[0] = dec_valid_q;
  assign stg_chan[0]  = dec_chan_q;
  assign stg_data[0]  = dec_data_q;

  for (genvar g = 0; g < N; g++) begin : g_comb
    cic_comb_bank #(
      .AW (AW),
      .CW (CW),
      .CH (CH),
      .M  (M)
    ) u_comb (
      .clk_i   (i_clk),
      .rst_i   (i_reset),
      .valid_i (stg_valid[g]),
      .chan_i  (stg_chan[g]),
      .data_i  (stg_data[g]),
      .valid_o (stg_valid[g+1]),
      .chan_o  (stg_chan[g+1]),
      .data_o  (stg_data[g+1])
    );
  end

  assign comb_shift = stg_data[N] >>> SHIFT;

  // Output next-state: scale and truncate the comb result when it is valid.
  always_comb begin
    o_ready_d = stg_valid[N];
    o_chan_d  = o_chan_q;
    o_data_d  = o_data_q;
    if (stg_valid[N]) begin
      o_chan_d = stg_chan[N];
      o_data_d = comb_shift[OW-1:0];
    end
  end

  // Output register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ready_q <= 1'b0;
      o_chan_q  <= '0;
      o_data_q  <= '0;
    end else begin
      o_ready_q <= o_ready_d;
      o_chan_q  <= o_chan_d;
      o_data_q  <= o_data_d;
    end
  end

  assign io.o_data     = o_data_q;
  assign io.o_ready    = o_ready_q;
  assign io.o_chan     = o_chan_q;
  assign io.o_sync_err = sync_err_q;

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Directed bench for cic_decimator_mc across several parameter sets.
module tb_cic_decimator_mc;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cic_decimator_mc_if #(.IW(19), .OW(19), .CW(1)) ifA ();
  cic_decimator_mc_if #(.IW(19), .OW(19), .CW(1)) ifB ();
  cic_decimator_mc_if #(.IW(19), .OW(19), .CW(1)) ifC ();
  cic_decimator_mc_if #(.IW(19), .OW(19), .CW(2)) ifD ();
  cic_decimator_mc_if #(.IW(19), .OW(19), .CW(1)) ifE ();

  cic_decimator_mc #(.IW(19), .OW(19), .N(1), .R(4), .M(1), .CH(1), .SHIFT(0))
    dutA (.i_clk(clk), .i_reset(rst), .io(ifA));
  cic_decimator_mc #(.IW(19), .OW(19), .N(2), .R(4), .M(1), .CH(1), .SHIFT(0))
    dutB (.i_clk(clk), .i_reset(rst | rst_b), .io(ifB));
  cic_decimator_mc #(.IW(19), .OW(19), .N(2), .R(4), .M(1), .CH(2), .SHIFT(0))
    dutC (.i_clk(clk), .i_reset(rst), .io(ifC));
  cic_decimator_mc #(.IW(19), .OW(19), .N(1), .R(2), .M(1), .CH(4), .SHIFT(0))
    dutD (.i_clk(clk), .i_reset(rst), .io(ifD));
  cic_decimator_mc #(.IW(19), .OW(19), .N(3), .R(16), .M(1), .CH(1), .SHIFT(12))
    dutE (.i_clk(clk), .i_reset(rst), .io(ifE));

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d_dat [17] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 1, 2, 3, 4, 1, 2, 3, 4};
    int d_fst [17] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
    int d_out [4]  = '{3, 4, 6, 8};
    logic exp_rdy;
    int   idx;

    {ifA.i_data, ifA.i_ready, ifA.i_first} = '0;
    {ifB.i_data, ifB.i_ready, ifB.i_first} = '0;
    {ifC.i_data, ifC.i_ready, ifC.i_first} = '0;
    {ifD.i_data, ifD.i_ready, ifD.i_first} = '0;
    {ifE.i_data, ifE.i_ready, ifE.i_first} = '0;
    rst   = 1'b1;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_A", {ifA.o_data, ifA.o_ready, ifA.o_chan, ifA.o_sync_err}, 0);
    chk("rst_B", {ifB.o_data, ifB.o_ready, ifB.o_chan, ifB.o_sync_err}, 0);
    chk("rst_C", {ifC.o_data, ifC.o_ready, ifC.o_chan, ifC.o_sync_err}, 0);
    chk("rst_D", {ifD.o_data, ifD.o_ready, ifD.o_chan, ifD.o_sync_err}, 0);
    chk("rst_E", {ifE.o_data, ifE.o_ready, ifE.o_chan, ifE.o_sync_err}, 0);
    rst = 1'b0;

    // A: N=1 R=4, B: N=2 R=4, E: N=3 R=16 full scale; constant input every cycle.
    for (int k = 1; k <= 80; k++) begin
      ifA.i_ready = 1'b1; ifA.i_first = 1'b1; ifA.i_data = 19'sd1;
      ifB.i_ready = 1'b1; ifB.i_first = 1'b1; ifB.i_data = 19'sd1;
      ifE.i_ready = 1'b1; ifE.i_first = 1'b1; ifE.i_data = 19'sd262143;
      @(posedge clk);
      #1;
      exp_rdy = (k >= 6) && ((k - 2) % 4 == 0);
      chk($sformatf("A_rdy@%0d", k), ifA.o_ready, exp_rdy);
      if (exp_rdy) begin
        chk($sformatf("A_dat@%0d", k), ifA.o_data, 4);
        chk($sformatf("A_chn@%0d", k), ifA.o_chan, 0);
      end
      exp_rdy = (k >= 7) && ((k - 3) % 4 == 0);
      chk($sformatf("B_rdy@%0d", k), ifB.o_ready, exp_rdy);
      if (exp_rdy) chk($sformatf("B_dat@%0d", k), ifB.o_data, (k == 7) ? 10 : 16);
      exp_rdy = (k >= 20) && ((k - 4) % 16 == 0);
      chk($sformatf("E_rdy@%0d", k), ifE.o_ready, exp_rdy);
      if (exp_rdy) begin
        idx = (k - 4) / 16;
        chk($sformatf("E_dat@%0d", k), ifE.o_data,
            (idx == 1) ? 52223 : (idx == 2) ? 226303 : 262143);
      end
    end

    // Sample 80 was decimating for B; reset on the very next edge drops it.
    ifA.i_ready = 1'b0;
    ifB.i_ready = 1'b0;
    ifE.i_ready = 1'b0;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    chk("B_rst", {ifB.o_data, ifB.o_ready, ifB.o_chan, ifB.o_sync_err}, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("B_drop@%0d", k), {ifB.o_data, ifB.o_ready, ifB.o_chan}, 0);
    end
    for (int k = 1; k <= 16; k++) begin
      ifB.i_ready = 1'b1; ifB.i_first = 1'b1; ifB.i_data = 19'sd1;
      @(posedge clk);
      #1;
      exp_rdy = (k >= 7) && ((k - 3) % 4 == 0);
      chk($sformatf("B2_rdy@%0d", k), ifB.o_ready, exp_rdy);
      if (exp_rdy) chk($sformatf("B2_dat@%0d", k), ifB.o_data, (k == 7) ? 10 : 16);
    end
    ifB.i_ready = 1'b0;

    // C: two interleaved channels, ch0=+1, ch1=-2.
    for (int k = 1; k <= 36; k++) begin
      ifC.i_ready = (k <= 32);
      ifC.i_first = (k % 2 == 1);
      ifC.i_data  = (k % 2 == 1) ? 19'sd1 : -19'sd2;
      @(posedge clk);
      #1;
      exp_rdy = (k >= 10) && (((k - 3) % 8 == 7) || ((k - 3) % 8 == 0));
      chk($sformatf("C_rdy@%0d", k), ifC.o_ready, exp_rdy);
      if (exp_rdy && ((k - 3) % 8 == 7)) begin
        chk($sformatf("C_chn@%0d", k), ifC.o_chan, 0);
        chk($sformatf("C_dat@%0d", k), ifC.o_data, (k == 10) ? 10 : 16);
      end
      if (exp_rdy && ((k - 3) % 8 == 0)) begin
        chk($sformatf("C_chn@%0d", k), ifC.o_chan, 1);
        chk($sformatf("C_dat@%0d", k), ifC.o_data, (k == 11) ? -20 : -32);
      end
    end
    chk("C_sync", ifC.o_sync_err, 0);

    // D: CH=4, N=1, R=2; i_first on the 2nd sample of the third frame.
    for (int k = 1; k <= 20; k++) begin
      if (k <= 17) begin
        ifD.i_ready = 1'b1;
        ifD.i_first = d_fst[k-1][0];
        ifD.i_data  = 19'(d_dat[k-1]);
      end else begin
        ifD.i_ready = 1'b0;
        ifD.i_first = 1'b0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("D_sync@%0d", k), ifD.o_sync_err, (k >= 10));
      exp_rdy = ((k >= 7) && (k <= 10)) || ((k >= 16) && (k <= 19));
      chk($sformatf("D_rdy@%0d", k), ifD.o_ready, exp_rdy);
      if (exp_rdy) begin
        chk($sformatf("D_chn@%0d", k), ifD.o_chan, (k <= 10) ? k - 7 : k - 16);
        chk($sformatf("D_dat@%0d", k), ifD.o_data, (k <= 10) ? 2 * (k - 6) : d_out[k-16]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
